urv_iram_loader: RTL and testbench
==================================

# urv_iram_loader

Boot-time image loader that drives one port of the uRV instruction/data RAM as its initiator. It accepts a byte stream from a host link (UART/SPI front-end) over a valid/ready handshake, assembles little-endian 32-bit words and writes them to consecutive RAM addresses. It optionally reads the image back and compares checksums. It holds the CPU in reset until a load completes successfully, and sits between the host link front-end and the RAM's second port.

## Interface
- `g_verify`, 1: 1 enables the readback/checksum pass; 0 skips it.
- `g_timeout`, 1000000: maximum idle cycles allowed between accepted bytes; 0 disables the timeout.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  load request; sampled only in IDLE.
- `base_i`  in  32  RAM byte base address; bits [1:0] are forced to 0.
- `nwords_i`  in  16  number of 32-bit words to load; captured on start.
- `rx_data_i`  in  8  stream byte.
- `rx_valid_i`  in  1  stream byte valid.
- `rx_ready_o`  out  1  loader accepts a byte this cycle.
- `mem_en_o`  out  1  RAM port enable.
- `mem_we_o`  out  1  RAM port write enable.
- `mem_a_o`  out  32  RAM byte address.
- `mem_bwe_o`  out  4  RAM byte write enables.
- `mem_d_o`  out  32  RAM write data.
- `mem_q_i`  in  32  RAM read data; valid one cycle after an enabled read.
- `busy_o`  out  1  a load is in progress.
- `done_o`  out  1  one-cycle pulse at the end of every load, successful or not.
- `err_o`  out  1  sticky error flag; cleared when the next load starts.
- `sum_o`  out  32  sum of received words, modulo 2^32.
- `cpu_rst_o`  out  1  CPU reset request.

## Operation
- States: IDLE, RECV, WRITE, VERIFY, DRAIN, CHECK, DONE.
- IDLE, with `start_i` = 1:
  - Capture `base_i` & ~3 and `nwords_i`.
  - Clear word index k, byte count, `sum_o`, readback sum and `err_o`.
  - Set `cpu_rst_o` = 1.
  - If `nwords_i` = 0, go to DONE; otherwise go to RECV.
- RECV:
  - `rx_ready_o` = 1.
  - Each byte with `rx_valid_i` = 1 is accepted. Byte j (0..3) goes to word bits [8j+7:8j], so the first byte is the LSB.
  - After the 4th byte, go to WRITE.
- WRITE, one cycle:
  - `mem_en_o` = `mem_we_o` = 1, `mem_bwe_o` = 4'hF.
  - `mem_a_o` = base + 4k, modulo 2^32; `mem_d_o` = assembled word.
  - `sum_o` += word; k++.
  - If k was the last word: go to VERIFY when `g_verify` = 1, otherwise to DONE. Else go back to RECV.
- VERIFY, n cycles:
  - Issue reads with `mem_en_o` = 1, `mem_we_o` = 0, `mem_bwe_o` = 0, `mem_a_o` = base + 4i for i = 0..n-1 on consecutive cycles.
  - `mem_q_i` is added to the readback sum on the cycle after each read.
- DRAIN, one cycle: capture the last readback word.
- CHECK, one cycle: `err_o` = (readback sum ≠ `sum_o`).
- DONE, one cycle:
  - `done_o` = 1.
  - `cpu_rst_o` ← `err_o`, so the CPU is released only on success.
  - Return to IDLE.
- Timeout:
  - An idle counter runs in RECV and clears on every accepted byte and on entry to RECV.
  - If `g_timeout` ≠ 0 and the counter reaches `g_timeout`, set `err_o` = 1 and go to DONE. No partial word is written.
- `start_i` outside IDLE is ignored.
- `rx_ready_o` = 0 in every state except RECV.
- All RAM port outputs are 0 when `mem_en_o` = 0.

## Timing
- Reset values: `rx_ready_o` = 0, `mem_*_o` = 0, `busy_o` = 0, `done_o` = 0, `err_o` = 0, `sum_o` = 0, `cpu_rst_o` = 1; state = IDLE.
- Reset asserted in any state takes effect at the next edge. RAM contents already written are left as they are.
- `start_i` high at edge t gives `busy_o` = 1 and RECV state from t+1; `busy_o` = 0 only in IDLE.
- Write latency: the 4th byte accepted at edge t produces the WRITE strobe during cycle t+1, and `rx_ready_o` is back at 1 from t+2. With a continuous stream each word takes 5 cycles.
- Verify for n words takes n + 2 cycles (VERIFY + DRAIN + CHECK), then 1 cycle of DONE.
- `nwords_i` = 0: DONE occurs in the cycle after start, with no RAM access, `err_o` = 0 and `cpu_rst_o` = 0 afterwards.
- Address wrap: base + 4k wraps modulo 2^32.
- The 16-bit word count allows up to 65535 words.

## Test plan
- Basic load: base = 0x100, n = 2, bytes 11 22 33 44 55 66 77 88 → writes of 0x44332211 @0x100 and 0x88776655 @0x104 with bwe = F. Then `sum_o` = 0xCCAA8866, `err_o` = 0, a single `done_o` pulse, and `cpu_rst_o` falls.
- Verify mismatch: the RAM model flips bit 0 of the readback for word 1 → `err_o` = 1 in CHECK, `done_o` pulses, and `cpu_rst_o` stays 1.
- Zero length and alignment: n = 0 → `done_o` one cycle after start with no `mem_en_o`. base = 0x103, n = 1 → write to 0x100.
- Wrap and back-pressure: base = 0xFFFFFFFC, n = 2, random gaps in `rx_valid_i` → writes to 0xFFFFFFFC then 0x00000000, with correct data regardless of gaps.
- Timeout: `g_timeout` = 16, send 3 bytes then stop → `err_o` = 1 and `done_o` exactly 16 idle cycles after the 3rd byte, with no write issued.
- Reset and start abuse: `rst_i` during RECV → all outputs at reset values next cycle. `start_i` pulsed during WRITE or VERIFY → ignored; the current load completes unchanged.

Source files
------------

// File: rtl/urv_iram_loader.sv
// Boot image loader: streams little-endian bytes into the uRV RAM second port,
// optionally reads the image back to compare checksums, and gates the CPU reset.
module urv_iram_loader #(
  parameter bit          g_verify  = 1'b1,
  parameter int unsigned g_timeout = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_i,
  input  logic [15:0] nwords_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_a_o,
  output logic [3:0]  mem_bwe_o,
  output logic [31:0] mem_d_o,
  input  logic [31:0] mem_q_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] sum_o,
  output logic        cpu_rst_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_VERIFY, S_DRAIN, S_CHECK, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [15:0] n_q, n_d;
  logic [15:0] k_q, k_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] sum_q, sum_d;
  logic [31:0] rsum_q, rsum_d;
  logic [31:0] idle_q, idle_d;
  logic        rd_pend_q, rd_pend_d;
  logic        err_q, err_d;
  logic        cpu_rst_q, cpu_rst_d;

  logic        accept;
  logic        timeout_hit;
  logic        last_k;
  logic [31:0] addr_k;
  logic [31:0] lane_d;

  assign accept      = (state_q == S_RECV) && rx_valid_i;
  assign timeout_hit = (g_timeout != 0) && !accept && (idle_q == g_timeout - 1);
  assign last_k      = (k_q == n_q - 16'd1);
  assign addr_k      = base_q + {14'd0, k_q, 2'b00};

  // Byte j of the word lands in lane j, so the first byte received is the LSB.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_d[8*gi +: 8] = (accept && bcnt_q == 2'(gi)) ? rx_data_i : word_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    n_d        = n_q;
    k_d        = k_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    sum_d      = sum_q;
    rsum_d     = rd_pend_q ? rsum_q + mem_q_i : rsum_q;
    idle_d     = idle_q;
    rd_pend_d  = 1'b0;
    err_d      = err_q;
    cpu_rst_d  = cpu_rst_q;
    rx_ready_o = 1'b0;
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_a_o    = '0;
    mem_bwe_o  = '0;
    mem_d_o    = '0;
    done_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d    = {base_i[31:2], 2'b00};
          n_d       = nwords_i;
          k_d       = '0;
          bcnt_d    = '0;
          sum_d     = '0;
          rsum_d    = '0;
          idle_d    = '0;
          err_d     = 1'b0;
          cpu_rst_d = 1'b1;
          state_d   = (nwords_i == 16'd0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        rx_ready_o = 1'b1;
        if (accept) begin
          word_d = lane_d;
          bcnt_d = bcnt_q + 2'd1;
          idle_d = '0;
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (g_timeout != 0) begin
          idle_d = idle_q + 32'd1;
        end
      end
      S_WRITE: begin
        mem_en_o  = 1'b1;
        mem_we_o  = 1'b1;
        mem_bwe_o = 4'hF;
        mem_a_o   = addr_k;
        mem_d_o   = word_q;
        sum_d     = sum_q + word_q;
        idle_d    = '0;
        if (last_k) begin
          k_d     = '0;
          state_d = g_verify ? S_VERIFY : S_DONE;
        end else begin
          k_d     = k_q + 16'd1;
          state_d = S_RECV;
        end
      end
      S_VERIFY: begin
        // Read data returns a cycle later and is folded in via rd_pend_q.
        mem_en_o  = 1'b1;
        mem_a_o   = addr_k;
        rd_pend_d = 1'b1;
        if (last_k) state_d = S_DRAIN;
        else        k_d     = k_q + 16'd1;
      end
      S_DRAIN: state_d = S_CHECK;
      S_CHECK: begin
        err_d   = (rsum_q != sum_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        done_o    = 1'b1;
        cpu_rst_d = err_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      n_q       <= '0;
      k_q       <= '0;
      bcnt_q    <= '0;
      word_q    <= '0;
      sum_q     <= '0;
      rsum_q    <= '0;
      idle_q    <= '0;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      n_q       <= n_d;
      k_q       <= k_d;
      bcnt_q    <= bcnt_d;
      word_q    <= word_d;
      sum_q     <= sum_d;
      rsum_q    <= rsum_d;
      idle_q    <= idle_d;
      rd_pend_q <= rd_pend_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign err_o     = err_q;
  assign sum_o     = sum_q;
  assign cpu_rst_o = cpu_rst_q;

endmodule

// File: tb/tb_urv_iram_loader.sv
// Bench for urv_iram_loader: a RAM model, a load-level scoreboard checked every
// cycle, and directed loads covering alignment, wrap, verify mismatch, timeout and reset.
module tb_urv_iram_loader;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_i = '0;
  logic [15:0] nwords_i = '0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o, mem_en_o, mem_we_o;
  logic [31:0] mem_a_o, mem_d_o;
  logic [3:0]  mem_bwe_o;
  logic [31:0] mem_q = '0;
  logic        busy_o, done_o, err_o, cpu_rst_o;
  logic [31:0] sum_o;

  always #5 clk = ~clk;

  urv_iram_loader #(.g_verify(1'b1), .g_timeout(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_i(base_i), .nwords_i(nwords_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_a_o(mem_a_o), .mem_bwe_o(mem_bwe_o),
    .mem_d_o(mem_d_o), .mem_q_i(mem_q), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .sum_o(sum_o), .cpu_rst_o(cpu_rst_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM with one-cycle read latency; can corrupt bit 0 of one address on readback.
  logic [31:0] ram [256];
  logic        flip_en = 1'b0;
  logic [31:0] flip_addr = '0;
  always @(posedge clk) begin
    if (mem_en_o && mem_we_o) ram[mem_a_o[9:2]] <= mem_d_o;
    if (mem_en_o && !mem_we_o)
      mem_q <= ram[mem_a_o[9:2]] ^ {31'd0, (flip_en && mem_a_o == flip_addr)};
  end

  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  wr_t         wr_log[$];
  logic [31:0] exp_sum = '0;
  logic        exp_err = 1'b0;
  logic [7:0]  none[$];
  int          no_gaps[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected behaviour of a complete load, derived from the byte list alone.
  task automatic model_load(input logic [31:0] base, input int n, input logic [7:0] bq[$],
                            input bit flip);
    logic [31:0] a, w;
    exp_wr.delete(); exp_rd.delete(); wr_log.delete();
    exp_sum = '0;
    for (int k = 0; k < n; k++) begin
      a = (base & 32'hFFFF_FFFC) + 32'(4 * k);
      w = {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]};
      exp_wr.push_back({a, w});
      exp_rd.push_back(a);
      exp_sum += w;
    end
    exp_err   = flip;
    flip_en   = flip;
    flip_addr = (base & 32'hFFFF_FFFC) + 32'd4;
  endtask

  // Per-cycle compare against the scoreboard.
  always @(negedge clk) begin
    if (mem_en_o && mem_we_o) begin
      wr_log.push_back({mem_a_o, mem_d_o});
      chk("write_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("write_addr", mem_a_o, e.a);
        chk("write_data", mem_d_o, e.d);
        chk("write_bwe", {28'd0, mem_bwe_o}, 32'hF);
      end
      $display("cyc=%0d WRITE a=%h d=%h", cyc, mem_a_o, mem_d_o);
    end else if (mem_en_o) begin
      chk("read_expected", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) chk("read_addr", mem_a_o, exp_rd.pop_front());
      chk("read_bwe", {28'd0, mem_bwe_o}, 32'd0);
      $display("cyc=%0d READ  a=%h", cyc, mem_a_o);
    end else begin
      chk("mem_idle_zero", mem_a_o | mem_d_o | {27'd0, mem_we_o, mem_bwe_o}, 32'd0);
    end
    if (busy_o) chk("cpu_rst_while_busy", {31'd0, cpu_rst_o}, 32'd1);
    else        chk("idle_outputs", {29'd0, rx_ready_o, mem_en_o, done_o}, 32'd0);
    if (done_o) begin
      chk("done_sum", sum_o, exp_sum);
      chk("done_err", {31'd0, err_o}, {31'd0, exp_err});
      chk("done_writes_left", 32'(exp_wr.size()), 32'd0);
      chk("done_reads_left", 32'(exp_rd.size()), 32'd0);
      $display("cyc=%0d DONE  sum=%h err=%0d", cyc, sum_o, err_o);
    end
  end

  task automatic start_load(input logic [31:0] base, input logic [15:0] n);
    base_i = base; nwords_i = n; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w = 0;
    rx_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data_i = b; rx_valid_i = 1'b1;
    while (!rx_ready_o && w < 50) begin @(negedge clk); w++; end
    chk("rx_ready_wait", {31'd0, rx_ready_o}, 32'd1);
    @(negedge clk);
    last_acc_cyc = cyc;
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int dc);
    int w = 0;
    while (!done_o && w < 200) begin @(negedge clk); w++; end
    chk({nm, "_done_seen"}, {31'd0, done_o}, 32'd1);
    dc = cyc;
    @(negedge clk);
    chk({nm, "_done_pulse"}, {31'd0, done_o}, 32'd0);
    chk({nm, "_busy_after"}, {31'd0, busy_o}, 32'd0);
    chk({nm, "_cpu_rst_after"}, {31'd0, cpu_rst_o}, {31'd0, exp_err});
  endtask

  task automatic run_load(input string nm, input logic [31:0] base, input logic [15:0] n,
                          input logic [7:0] bq[$], input int gq[$], input bit flip,
                          input bit abuse);
    int dc;
    model_load(base, int'(n), bq, flip);
    start_load(base, n);
    for (int i = 0; i < bq.size(); i++) send_byte(bq[i], (i < gq.size()) ? gq[i] : 0);
    if (abuse) begin
      // Now in the WRITE cycle of the last word; then the first VERIFY cycle.
      start_i = 1'b1; base_i = 32'hDEAD_0000; nwords_i = 16'd7;
      repeat (2) @(negedge clk);
      start_i = 1'b0;
    end
    wait_done(nm, dc);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [7:0] bq[$];
    int gq[$];
    int dc;

    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'd0, rx_ready_o}, 32'd0);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_err", {31'd0, err_o}, 32'd0);
    chk("reset_sum", sum_o, 32'd0);
    chk("reset_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);

    // Basic two-word load.
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load("basic", 32'h100, 16'd2, bq, no_gaps, 1'b0, 1'b0);
    chk("basic_sum_lit", sum_o, 32'hCCAA8866);
    chk("basic_cpu_rst_lit", {31'd0, cpu_rst_o}, 32'd0);
    chk("basic_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() >= 2) begin
      chk("basic_w0_addr_lit", wr_log[0].a, 32'h100);
      chk("basic_w0_data_lit", wr_log[0].d, 32'h44332211);
      chk("basic_w1_addr_lit", wr_log[1].a, 32'h104);
      chk("basic_w1_data_lit", wr_log[1].d, 32'h88776655);
    end

    // Readback of word 1 corrupted.
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    run_load("mismatch", 32'h300, 16'd2, bq, no_gaps, 1'b1, 1'b0);
    chk("mismatch_err_lit", {31'd0, err_o}, 32'd1);
    chk("mismatch_cpu_rst_lit", {31'd0, cpu_rst_o}, 32'd1);

    // Zero length: DONE immediately after start, error cleared, CPU released.
    model_load(32'h500, 0, none, 1'b0);
    start_load(32'h500, 16'd0);
    chk("zero_done_lit", {31'd0, done_o}, 32'd1);
    chk("zero_no_mem", {31'd0, mem_en_o}, 32'd0);
    chk("zero_err_lit", {31'd0, err_o}, 32'd0);
    @(negedge clk);
    chk("zero_pulse", {31'd0, done_o}, 32'd0);
    chk("zero_cpu_rst_lit", {31'd0, cpu_rst_o}, 32'd0);

    // Misaligned base, with start pulsed during WRITE and VERIFY.
    bq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("align", 32'h103, 16'd1, bq, no_gaps, 1'b0, 1'b1);
    chk("align_nwr", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() >= 1) chk("align_addr_lit", wr_log[0].a, 32'h100);
    chk("align_sum_lit", sum_o, 32'hDEADBEEF);

    // Address wrap with gaps in the stream.
    bq = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
    gq = '{3, 0, 5, 1, 0, 7, 2, 4};
    run_load("wrap", 32'hFFFF_FFFC, 16'd2, bq, gq, 1'b0, 1'b0);
    chk("wrap_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() >= 2) begin
      chk("wrap_w0_addr_lit", wr_log[0].a, 32'hFFFF_FFFC);
      chk("wrap_w1_addr_lit", wr_log[1].a, 32'h0000_0000);
      chk("wrap_w1_data_lit", wr_log[1].d, 32'hFEDCBA98);
    end

    // Timeout: three bytes then silence.
    model_load(32'h600, 0, none, 1'b0);
    exp_err = 1'b1;
    start_load(32'h600, 16'd1);
    send_byte(8'h5A, 0);
    send_byte(8'h5B, 0);
    send_byte(8'h5C, 0);
    wait_done("timeout", dc);
    chk("timeout_latency", 32'(dc), 32'(last_acc_cyc + 16));
    chk("timeout_err_lit", {31'd0, err_o}, 32'd1);

    // Reset in RECV after one word was written.
    bq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    model_load(32'h200, 2, bq, 1'b0);
    start_load(32'h200, 16'd2);
    for (int i = 0; i < 5; i++) send_byte(bq[i], 0);
    chk("rst_pre_sum_lit", sum_o, 32'hD4C3B2A1);
    exp_wr.delete(); exp_rd.delete();
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, rx_ready_o}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_sum", sum_o, 32'd0);
    chk("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    rst_i = 1'b0;
    @(negedge clk);

    // Recovery after reset.
    bq = '{8'h01, 8'h00, 8'h00, 8'h80};
    run_load("recover", 32'h40, 16'd1, bq, no_gaps, 1'b0, 1'b0);
    chk("recover_sum_lit", sum_o, 32'h80000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
